bram_arb2: RTL and testbench

Two-master arbiter that shares the single `bram_axi` 16-bit framebuffer/pattern memory slave between two AXI-lite-style requesters: m0 (CPU) and m1 (display scanout). One transaction (read or write) is in flight at a time. Masters are granted round-robin, and the granted master's channels are routed straight to the slave port. The block sits between the requesters and the BRAM slave, in the same clock domain.

---
 rtl/bram_arb2.sv | 241 ++++++++++++++++++++++++
 tb/tb_bram_arb2.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arb2.sv
// -----------------------------------------------------------------------------
// bram_arb2 -- two-master arbiter in front of the single bram_axi slave.
//
// m0 (CPU) and m1 (display scanout) share one 16-bit BRAM slave. One read or
// write is in flight at a time. The granted master's channels are routed
// straight through to the slave port. The arbiter adds no buffering, so masters
// must hold their address and data stable until ready.
//
// Ports
//   a_clk, a_rst_n     clock (rising edge), asynchronous active-low reset
//   mN_aw_*/mN_w_*     write address / data from master N (N = 0, 1)
//   mN_b_*             write response to master N
//   mN_ar_*            read address from master N
//   mN_r_*             read data / response to master N
//   s_*                the same channels toward bram_axi, directions mirrored
//   gnt                one-hot current grant, 00 while idle
//
// Configuration
//   BRAM_ARB_FIXED_PRIO_EN  defined: m0 always wins a tie and there is no
//                           round-robin pointer, so m1 can starve.
//                           undefined (default): round-robin on ties.
// -----------------------------------------------------------------------------
module bram_arb2 (
    input  logic        a_clk,
    input  logic        a_rst_n,
    // master 0
    input  logic        m0_aw_valid,
    output logic        m0_aw_ready,
    input  logic [17:0] m0_aw_addr,
    input  logic        m0_aw_prot,
    input  logic        m0_w_valid,
    output logic        m0_w_ready,
    input  logic [15:0] m0_w_data,
    input  logic [1:0]  m0_w_strb,
    output logic        m0_b_valid,
    input  logic        m0_b_ready,
    output logic [1:0]  m0_b_resp,
    input  logic        m0_ar_valid,
    output logic        m0_ar_ready,
    input  logic [17:0] m0_ar_addr,
    input  logic        m0_ar_prot,
    output logic        m0_r_valid,
    input  logic        m0_r_ready,
    output logic [15:0] m0_r_data,
    output logic [1:0]  m0_r_resp,
    // master 1
    input  logic        m1_aw_valid,
    output logic        m1_aw_ready,
    input  logic [17:0] m1_aw_addr,
    input  logic        m1_aw_prot,
    input  logic        m1_w_valid,
    output logic        m1_w_ready,
    input  logic [15:0] m1_w_data,
    input  logic [1:0]  m1_w_strb,
    output logic        m1_b_valid,
    input  logic        m1_b_ready,
    output logic [1:0]  m1_b_resp,
    input  logic        m1_ar_valid,
    output logic        m1_ar_ready,
    input  logic [17:0] m1_ar_addr,
    input  logic        m1_ar_prot,
    output logic        m1_r_valid,
    input  logic        m1_r_ready,
    output logic [15:0] m1_r_data,
    output logic [1:0]  m1_r_resp,
    // slave (bram_axi)
    output logic        s_aw_valid,
    input  logic        s_aw_ready,
    output logic [17:0] s_aw_addr,
    output logic        s_aw_prot,
    output logic        s_w_valid,
    input  logic        s_w_ready,
    output logic [15:0] s_w_data,
    output logic [1:0]  s_w_strb,
    input  logic        s_b_valid,
    output logic        s_b_ready,
    input  logic [1:0]  s_b_resp,
    output logic        s_ar_valid,
    input  logic        s_ar_ready,
    output logic [17:0] s_ar_addr,
    output logic        s_ar_prot,
    input  logic        s_r_valid,
    output logic        s_r_ready,
    input  logic [15:0] s_r_data,
    input  logic [1:0]  s_r_resp,
    // grant
    output logic [1:0]  gnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [1:0] gnt_q, gnt_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic req0, req1, win1;
    logic g0, g1, rd, wr;
    logic g_ar_valid, g_aw_valid, g_w_valid, g_r_ready, g_b_ready;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs, xfer_done;

    assign req0 = m0_ar_valid | (m0_aw_valid & m0_w_valid);
    assign req1 = m1_ar_valid | (m1_aw_valid & m1_w_valid);

    assign g0 = gnt_q[0];
    assign g1 = gnt_q[1];
    assign rd = (state_q == READ);
    assign wr = (state_q == WRITE);

    // Handshakes. Slave valids/readies are already qualified by state.
    assign ar_hs     = s_ar_valid & s_ar_ready;
    assign aw_hs     = s_aw_valid & s_aw_ready;
    assign w_hs      = s_w_valid  & s_w_ready;
    assign r_hs      = s_r_valid  & s_r_ready;
    assign b_hs      = s_b_valid  & s_b_ready;
    assign xfer_done = r_hs | b_hs;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    // m0 always wins a tie.
    assign win1 = req1 & ~req0;
`else
    // last_q names the master that most recently completed a transaction;
    // the other one wins a tie. Resets to 1 so m0 wins the first tie.
    logic last_q;

    assign win1 = req1 & (~req0 | ~last_q);

    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            last_q <= 1'b1;
        end else if (xfer_done) begin
            last_q <= g1;
        end
    end
`endif

    // Granted master's control signals. gnt_q is 00 in IDLE, which also
    // forces every routed address/data bus to zero there.
    assign g_ar_valid = (g0 & m0_ar_valid) | (g1 & m1_ar_valid);
    assign g_aw_valid = (g0 & m0_aw_valid) | (g1 & m1_aw_valid);
    assign g_w_valid  = (g0 & m0_w_valid)  | (g1 & m1_w_valid);
    assign g_r_ready  = (g0 & m0_r_ready)  | (g1 & m1_r_ready);
    assign g_b_ready  = (g0 & m0_b_ready)  | (g1 & m1_b_ready);

    // Slave side: each address/data channel stops once its handshake is done.
    assign s_ar_valid = rd & g_ar_valid & ~ar_done_q;
    assign s_ar_addr  = ({18{g0}} & m0_ar_addr) | ({18{g1}} & m1_ar_addr);
    assign s_ar_prot  = (g0 & m0_ar_prot) | (g1 & m1_ar_prot);
    assign s_r_ready  = rd & g_r_ready;

    assign s_aw_valid = wr & g_aw_valid & ~aw_done_q;
    assign s_aw_addr  = ({18{g0}} & m0_aw_addr) | ({18{g1}} & m1_aw_addr);
    assign s_aw_prot  = (g0 & m0_aw_prot) | (g1 & m1_aw_prot);
    assign s_w_valid  = wr & g_w_valid & ~w_done_q;
    assign s_w_data   = ({16{g0}} & m0_w_data) | ({16{g1}} & m1_w_data);
    assign s_w_strb   = ({2{g0}} & m0_w_strb) | ({2{g1}} & m1_w_strb);
    assign s_b_ready  = wr & g_b_ready;

    // Master side: non-granted master sees all zeros.
    assign m0_ar_ready = g0 & ar_hs;
    assign m0_aw_ready = g0 & aw_hs;
    assign m0_w_ready  = g0 & w_hs;
    assign m0_r_valid  = g0 & rd & s_r_valid;
    assign m0_r_data   = {16{g0 & rd}} & s_r_data;
    assign m0_r_resp   = {2{g0 & rd}} & s_r_resp;
    assign m0_b_valid  = g0 & wr & s_b_valid;
    assign m0_b_resp   = {2{g0 & wr}} & s_b_resp;

    assign m1_ar_ready = g1 & ar_hs;
    assign m1_aw_ready = g1 & aw_hs;
    assign m1_w_ready  = g1 & w_hs;
    assign m1_r_valid  = g1 & rd & s_r_valid;
    assign m1_r_data   = {16{g1 & rd}} & s_r_data;
    assign m1_r_resp   = {2{g1 & rd}} & s_r_resp;
    assign m1_b_valid  = g1 & wr & s_b_valid;
    assign m1_b_resp   = {2{g1 & wr}} & s_b_resp;

    assign gnt = gnt_q;

    always_ff @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= 2'b00;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ar_done_d = ar_done_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    gnt_d     = win1 ? 2'b10 : 2'b01;
                    // A pending read beats a pending write of the same master.
                    state_d   = (win1 ? m1_ar_valid : m0_ar_valid) ? READ : WRITE;
                    ar_done_d = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            READ: begin
                if (ar_hs) ar_done_d = 1'b1;
                if (r_hs) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            WRITE: begin
                if (aw_hs) aw_done_d = 1'b1;
                if (w_hs)  w_done_d  = 1'b1;
                if (b_hs) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_bram_arb2.sv
// -----------------------------------------------------------------------------
// tb_bram_arb2 -- directed bench for bram_arb2 with a small behavioural
// bram_axi model: the slave raises ar_ready+r_valid (or aw/w_ready+b_valid)
// one cycle after seeing the request, and holds the response until ready.
// -----------------------------------------------------------------------------
module tb_bram_arb2;

`ifdef BRAM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic a_clk = 1'b0;
    logic a_rst_n = 1'b1;

    logic        m0_aw_valid, m0_aw_ready, m0_aw_prot, m0_w_valid, m0_w_ready;
    logic [17:0] m0_aw_addr, m0_ar_addr;
    logic [15:0] m0_w_data, m0_r_data;
    logic [1:0]  m0_w_strb, m0_b_resp, m0_r_resp;
    logic        m0_b_valid, m0_b_ready, m0_ar_valid, m0_ar_ready, m0_ar_prot;
    logic        m0_r_valid, m0_r_ready;

    logic        m1_aw_valid, m1_aw_ready, m1_aw_prot, m1_w_valid, m1_w_ready;
    logic [17:0] m1_aw_addr, m1_ar_addr;
    logic [15:0] m1_w_data, m1_r_data;
    logic [1:0]  m1_w_strb, m1_b_resp, m1_r_resp;
    logic        m1_b_valid, m1_b_ready, m1_ar_valid, m1_ar_ready, m1_ar_prot;
    logic        m1_r_valid, m1_r_ready;

    logic        s_aw_valid, s_aw_ready, s_aw_prot, s_w_valid, s_w_ready;
    logic [17:0] s_aw_addr, s_ar_addr;
    logic [15:0] s_w_data, s_r_data;
    logic [1:0]  s_w_strb, s_b_resp, s_r_resp;
    logic        s_b_valid, s_b_ready, s_ar_valid, s_ar_ready, s_ar_prot;
    logic        s_r_valid, s_r_ready;
    logic [1:0]  gnt;

    int checks = 0;
    int errors = 0;
    logic [1:0] eg;

    always #5 a_clk = ~a_clk;

    bram_arb2 dut (
        .a_clk(a_clk), .a_rst_n(a_rst_n),
        .m0_aw_valid(m0_aw_valid), .m0_aw_ready(m0_aw_ready), .m0_aw_addr(m0_aw_addr),
        .m0_aw_prot(m0_aw_prot), .m0_w_valid(m0_w_valid), .m0_w_ready(m0_w_ready),
        .m0_w_data(m0_w_data), .m0_w_strb(m0_w_strb), .m0_b_valid(m0_b_valid),
        .m0_b_ready(m0_b_ready), .m0_b_resp(m0_b_resp), .m0_ar_valid(m0_ar_valid),
        .m0_ar_ready(m0_ar_ready), .m0_ar_addr(m0_ar_addr), .m0_ar_prot(m0_ar_prot),
        .m0_r_valid(m0_r_valid), .m0_r_ready(m0_r_ready), .m0_r_data(m0_r_data),
        .m0_r_resp(m0_r_resp),
        .m1_aw_valid(m1_aw_valid), .m1_aw_ready(m1_aw_ready), .m1_aw_addr(m1_aw_addr),
        .m1_aw_prot(m1_aw_prot), .m1_w_valid(m1_w_valid), .m1_w_ready(m1_w_ready),
        .m1_w_data(m1_w_data), .m1_w_strb(m1_w_strb), .m1_b_valid(m1_b_valid),
        .m1_b_ready(m1_b_ready), .m1_b_resp(m1_b_resp), .m1_ar_valid(m1_ar_valid),
        .m1_ar_ready(m1_ar_ready), .m1_ar_addr(m1_ar_addr), .m1_ar_prot(m1_ar_prot),
        .m1_r_valid(m1_r_valid), .m1_r_ready(m1_r_ready), .m1_r_data(m1_r_data),
        .m1_r_resp(m1_r_resp),
        .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr),
        .s_aw_prot(s_aw_prot), .s_w_valid(s_w_valid), .s_w_ready(s_w_ready),
        .s_w_data(s_w_data), .s_w_strb(s_w_strb), .s_b_valid(s_b_valid),
        .s_b_ready(s_b_ready), .s_b_resp(s_b_resp), .s_ar_valid(s_ar_valid),
        .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot),
        .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp),
        .gnt(gnt)
    );

    // ---------------- behavioural bram_axi ----------------
    logic [15:0] mem [0:262143];
    logic        sl_ar_rdy, sl_r_vld, sl_aw_rdy, sl_b_vld;
    logic [15:0] sl_r_data;
    logic        pre_we;
    logic [17:0] pre_addr;
    logic [15:0] pre_data;

    assign s_ar_ready = sl_ar_rdy;
    assign s_r_valid  = sl_r_vld;
    assign s_r_data   = sl_r_data;
    assign s_r_resp   = 2'b00;
    assign s_aw_ready = sl_aw_rdy;
    assign s_w_ready  = sl_aw_rdy;
    assign s_b_valid  = sl_b_vld;
    assign s_b_resp   = 2'b00;

    always @(posedge a_clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            sl_ar_rdy <= 1'b0;
            sl_r_vld  <= 1'b0;
            sl_r_data <= 16'h0;
            sl_aw_rdy <= 1'b0;
            sl_b_vld  <= 1'b0;
        end else begin
            sl_ar_rdy <= 1'b0;
            sl_aw_rdy <= 1'b0;
            if (s_ar_valid && !sl_ar_rdy && !sl_r_vld) begin
                sl_ar_rdy <= 1'b1;
                sl_r_vld  <= 1'b1;
                sl_r_data <= mem[s_ar_addr];
            end else if (sl_r_vld && s_r_ready) begin
                sl_r_vld <= 1'b0;
            end
            if (s_aw_valid && s_w_valid && !sl_aw_rdy && !sl_b_vld) begin
                sl_aw_rdy       <= 1'b1;
                sl_b_vld        <= 1'b1;
                mem[s_aw_addr]  <= s_w_data;
            end else if (sl_b_vld && s_b_ready) begin
                sl_b_vld <= 1'b0;
            end
            if (pre_we) mem[pre_addr] <= pre_data;
        end
    end

    // ---------------- output summaries ----------------
    logic any_out, m0_any, m1_any;
    assign m0_any = |{m0_aw_ready, m0_w_ready, m0_b_valid, m0_b_resp, m0_ar_ready,
                      m0_r_valid, m0_r_data, m0_r_resp};
    assign m1_any = |{m1_aw_ready, m1_w_ready, m1_b_valid, m1_b_resp, m1_ar_ready,
                      m1_r_valid, m1_r_data, m1_r_resp};
    assign any_out = m0_any | m1_any | (|gnt) |
                     (|{s_aw_valid, s_aw_addr, s_aw_prot, s_w_valid, s_w_data, s_w_strb,
                        s_b_ready, s_ar_valid, s_ar_addr, s_ar_prot, s_r_ready});

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge a_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        m0_aw_valid = 0; m0_aw_addr = '0; m0_aw_prot = 0; m0_w_valid = 0;
        m0_w_data = '0; m0_w_strb = '0; m0_b_ready = 0; m0_ar_valid = 0;
        m0_ar_addr = '0; m0_ar_prot = 0; m0_r_ready = 0;
        m1_aw_valid = 0; m1_aw_addr = '0; m1_aw_prot = 0; m1_w_valid = 0;
        m1_w_data = '0; m1_w_strb = '0; m1_b_ready = 0; m1_ar_valid = 0;
        m1_ar_addr = '0; m1_ar_prot = 0; m1_r_ready = 0;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        pre_we = 0; pre_addr = '0; pre_data = '0;
        #1 a_rst_n = 1'b0;
        #2;
        chk("reset_all_zero", any_out, 0);
        chk("reset_gnt", gnt, 2'b00);
        @(negedge a_clk);
        a_rst_n = 1'b1;

        // preload memory[0x010] = 0xABCD through the model
        tick(); pre_we = 1; pre_addr = 18'h00010; pre_data = 16'hABCD;
        tick(); pre_we = 0;

        // ---- single read by m0 ----
        m0_ar_valid = 1; m0_ar_addr = 18'h00010; m0_ar_prot = 1; m0_r_ready = 1; settle();
        chk("rd0_c0_gnt", gnt, 2'b00);
        tick();
        chk("rd0_c1_gnt", gnt, 2'b01);
        chk("rd0_c1_s_ar_valid", s_ar_valid, 1);
        chk("rd0_c1_s_ar_addr", s_ar_addr, 18'h00010);
        chk("rd0_c1_s_ar_prot", s_ar_prot, 1);
        chk("rd0_c1_r_valid", m0_r_valid, 0);
        tick();
        chk("rd0_c2_gnt", gnt, 2'b01);
        chk("rd0_c2_ar_ready", m0_ar_ready, 1);
        chk("rd0_c2_r_valid", m0_r_valid, 1);
        chk("rd0_c2_r_data", m0_r_data, 16'hABCD);
        chk("rd0_c2_r_resp", m0_r_resp, 2'b00);
        chk("rd0_c2_s_r_ready", s_r_ready, 1);
        chk("rd0_c2_m1_quiet", m1_any, 0);
        tick(); m0_ar_valid = 0; m0_ar_prot = 0; settle();
        chk("rd0_c3_gnt", gnt, 2'b00);
        chk("rd0_c3_all_zero", any_out, 0);

        // ---- m1 writes 0xBEEF to 0x123, then reads it back ----
        m1_aw_valid = 1; m1_aw_addr = 18'h00123; m1_aw_prot = 1;
        m1_w_valid = 1; m1_w_data = 16'hBEEF; m1_w_strb = 2'b11; m1_b_ready = 1; settle();
        chk("wr1_c0_gnt", gnt, 2'b00);
        tick();
        chk("wr1_c1_gnt", gnt, 2'b10);
        chk("wr1_c1_s_aw_valid", s_aw_valid, 1);
        chk("wr1_c1_s_w_valid", s_w_valid, 1);
        chk("wr1_c1_s_aw_addr", s_aw_addr, 18'h00123);
        chk("wr1_c1_s_aw_prot", s_aw_prot, 1);
        chk("wr1_c1_s_w_data", s_w_data, 16'hBEEF);
        chk("wr1_c1_s_w_strb", s_w_strb, 2'b11);
        chk("wr1_c1_s_ar_valid", s_ar_valid, 0);
        chk("wr1_c1_m0_quiet", m0_any, 0);
        tick();
        chk("wr1_c2_aw_ready", m1_aw_ready, 1);
        chk("wr1_c2_w_ready", m1_w_ready, 1);
        chk("wr1_c2_b_valid", m1_b_valid, 1);
        chk("wr1_c2_b_resp", m1_b_resp, 2'b00);
        chk("wr1_c2_s_b_ready", s_b_ready, 1);
        chk("wr1_c2_m0_quiet", m0_any, 0);
        tick();
        m1_aw_valid = 0; m1_w_valid = 0; m1_aw_prot = 0;
        m1_ar_valid = 1; m1_ar_addr = 18'h00123; m1_r_ready = 1; settle();
        chk("wr1_c3_gnt", gnt, 2'b00);
        chk("wr1_c3_b_valid", m1_b_valid, 0);
        tick();
        chk("rd1_c1_gnt", gnt, 2'b10);
        chk("rd1_c1_s_ar_addr", s_ar_addr, 18'h00123);
        tick();
        chk("rd1_c2_r_valid", m1_r_valid, 1);
        chk("rd1_c2_r_data", m1_r_data, 16'hBEEF);
        chk("rd1_c2_m0_quiet", m0_any, 0);
        tick(); m1_ar_valid = 0; settle();
        chk("rd1_c3_gnt", gnt, 2'b00);

        // ---- tie: both read continuously ----
        m0_ar_valid = 1; m0_ar_addr = 18'h00010; m0_r_ready = 1;
        m1_ar_valid = 1; m1_ar_addr = 18'h00123; m1_r_ready = 1; settle();
        for (int k = 0; k < 4; k++) begin
            eg = (FIXED || (k % 2 == 0)) ? 2'b01 : 2'b10;
            tick();
            chk($sformatf("tie%0d_gnt", k), gnt, eg);
            tick();
            chk($sformatf("tie%0d_rvalid", k), {m1_r_valid, m0_r_valid}, eg);
            tick();
            chk($sformatf("tie%0d_idle", k), gnt, 2'b00);
        end
        m0_ar_valid = 0; m1_ar_valid = 0;

        // ---- backpressure: m0 r_ready low 5 cycles, m1 waiting ----
        m0_ar_valid = 1; m0_ar_addr = 18'h00010; m0_r_ready = 0;
        m1_ar_valid = 1; m1_ar_addr = 18'h00123; m1_r_ready = 1; settle();
        tick();
        chk("bp_c1_gnt", gnt, 2'b01);
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 1) m0_ar_valid = 0;
            settle();
            chk($sformatf("bp%0d_s_r_valid", k), s_r_valid, 1);
            chk($sformatf("bp%0d_m0_r_valid", k), m0_r_valid, 1);
            chk($sformatf("bp%0d_gnt", k), gnt, 2'b01);
            chk($sformatf("bp%0d_m1_quiet", k), m1_any, 0);
        end
        tick(); m0_r_ready = 1; settle();
        chk("bp_release_r_valid", m0_r_valid, 1);
        chk("bp_release_r_data", m0_r_data, 16'hABCD);
        tick();
        chk("bp_idle_gnt", gnt, 2'b00);
        tick();
        chk("bp_m1_gnt", gnt, 2'b10);
        tick();
        chk("bp_m1_r_data", m1_r_data, 16'hBEEF);
        tick(); m1_ar_valid = 0; settle();
        chk("bp_end_gnt", gnt, 2'b00);

        // ---- m0 reads m1's data so m0 is the last served ----
        m0_ar_valid = 1; m0_ar_addr = 18'h00123; settle();
        tick(); tick();
        chk("x_rd_data", m0_r_data, 16'hBEEF);
        tick(); m0_ar_valid = 0; settle();

        // ---- reset in the WRITE state after the aw handshake ----
        m1_aw_valid = 1; m1_aw_addr = 18'h00055; m1_w_valid = 1;
        m1_w_data = 16'h1234; m1_w_strb = 2'b01; m1_b_ready = 0; settle();
        tick();
        chk("rw_c1_gnt", gnt, 2'b10);
        chk("rw_c1_s_w_strb", s_w_strb, 2'b01);
        tick();
        chk("rw_c2_aw_ready", m1_aw_ready, 1);
        chk("rw_c2_b_valid", m1_b_valid, 1);
        tick(); m1_aw_valid = 0; m1_w_valid = 0; settle();
        chk("rw_c3_b_valid", m1_b_valid, 1);
        chk("rw_c3_s_aw_valid", s_aw_valid, 0);
        chk("rw_c3_gnt", gnt, 2'b10);
        #2 a_rst_n = 1'b0;
        #1;
        chk("rw_rst_all_zero", any_out, 0);
        chk("rw_rst_gnt", gnt, 2'b00);
        clear_inputs();
        @(negedge a_clk);
        a_rst_n = 1'b1;
        m0_ar_valid = 1; m0_ar_addr = 18'h00010; m0_r_ready = 1;
        m1_ar_valid = 1; m1_ar_addr = 18'h00123; m1_r_ready = 1;
        tick();
        chk("post_rst_tie_gnt", gnt, 2'b01);
        tick();
        chk("post_rst_r_data", m0_r_data, 16'hABCD);
        tick(); clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
